// File: rtl/mem_if_axi_bridge_if.sv
// rtl/mem_if_axi_bridge_if.sv - cpu_mem AXI4 single-beat bus between the bridge and the crossbar
interface mem_if_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [7:0]              arlen;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rlast;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [7:0]              awlen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wlast;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, arsize, arburst, arlen,
        input  arready,
        input  rdata, rvalid, rlast,
        output rready,
        output awaddr, awvalid, awsize, awburst, awlen,
        input  awready,
        output wdata, wstrb, wvalid, wlast,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid, arsize, arburst, arlen,
        output arready,
        output rdata, rvalid, rlast,
        input  rready,
        input  awaddr, awvalid, awsize, awburst, awlen,
        output awready,
        input  wdata, wstrb, wvalid, wlast,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/mem_if_axi_bridge.sv
// rtl/mem_if_axi_bridge.sv - CPU load/store port to single-beat AXI4 master, one transaction outstanding
module mem_if_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic                    MemWrite,
    input  logic                    MemRead,
    input  logic [DATA_WIDTH-1:0]   Write_data,
    input  logic [DATA_WIDTH/8-1:0] Write_strb,
    output logic                    Mem_Req_Ready,
    output logic [DATA_WIDTH-1:0]   Read_data,
    output logic                    Read_data_Valid,
    input  logic                    Read_data_Ready,
    mem_if_axi_bridge_if.master     cpu_mem
);
    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        RD_RET,
        WR_REQ,
        WR_B
    } state_t;

    // Bus addresses are word aligned; byte selection travels on wstrb.
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    req_ready_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    beat_seen;
    logic                    accept;

    // req_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept = (MemRead | MemWrite) & req_ready_q;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a simultaneous read and write request is taken as a write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MemWrite ? WR_REQ : RD_AR;
            RD_AR:   if (cpu_mem.arready) state_next = RD_R;
            RD_R:    if (cpu_mem.rvalid && cpu_mem.rlast) state_next = RD_RET;
            RD_RET:  if (Read_data_Ready) state_next = IDLE;
            WR_REQ:  if ((aw_done || cpu_mem.awready) && (w_done || cpu_mem.wready)) state_next = WR_B;
            WR_B:    if (cpu_mem.bvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, per-channel write completion flags and first-beat read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            read_data_q <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            beat_seen   <= 1'b0;
        end else begin
            req_ready_q <= (state_next == IDLE);
            if (state == IDLE && accept) begin
                addr_q    <= Address;
                wdata_q   <= Write_data;
                strb_q    <= Write_strb;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                beat_seen <= 1'b0;
            end
            if (state == WR_REQ) begin
                if (cpu_mem.awready) aw_done <= 1'b1;
                if (cpu_mem.wready)  w_done  <= 1'b1;
            end
            if (state == RD_R && cpu_mem.rvalid && !beat_seen) begin
                read_data_q <= cpu_mem.rdata;
                beat_seen   <= 1'b1;
            end
        end
    end

    // Handshake outputs decode straight from registered state, never from AXI inputs.
    assign Mem_Req_Ready    = req_ready_q;
    assign Read_data        = read_data_q;
    assign Read_data_Valid  = (state == RD_RET);

    assign cpu_mem.araddr   = addr_q & WORD_MASK;
    assign cpu_mem.arvalid  = (state == RD_AR);
    assign cpu_mem.arsize   = 3'b010;
    assign cpu_mem.arburst  = 2'b01;
    assign cpu_mem.arlen    = 8'd0;
    assign cpu_mem.rready   = (state == RD_R);

    assign cpu_mem.awaddr   = addr_q & WORD_MASK;
    assign cpu_mem.awvalid  = (state == WR_REQ) && !aw_done;
    assign cpu_mem.awsize   = 3'b010;
    assign cpu_mem.awburst  = 2'b01;
    assign cpu_mem.awlen    = 8'd0;
    assign cpu_mem.wdata    = wdata_q;
    assign cpu_mem.wstrb    = strb_q;
    assign cpu_mem.wvalid   = (state == WR_REQ) && !w_done;
    assign cpu_mem.wlast    = 1'b1;
    assign cpu_mem.bready   = (state == WR_B);
endmodule
